// File: rtl/f2i_share_ctrl_if.sv
// Request/response and converter-side bundle for the shared float-to-int controller.
// Latency: none, this is wiring only.
// Backpressure: carries per-requester valid/ready for requests and responses.
// Signals: req_valid/req_data/req_ready (operand issue), resp_valid/resp_ready/
// resp_data/resp_err (result return), busy, cvt_a/cvt_rst/cvt_z/cvt_z_stb (converter).
// slave = the controller, master = requesters plus converter.
interface f2i_share_ctrl_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    resp_valid;
  logic [NREQ-1:0]    resp_ready;
  logic [31:0]        resp_data;
  logic               resp_err;
  logic               busy;
  logic [31:0]        cvt_a;
  logic               cvt_rst;
  logic [31:0]        cvt_z;
  logic               cvt_z_stb;

  modport slave (
    input  req_valid, req_data, resp_ready, cvt_z, cvt_z_stb,
    output req_ready, resp_valid, resp_data, resp_err, busy, cvt_a, cvt_rst
  );

  modport master (
    output req_valid, req_data, resp_ready, cvt_z, cvt_z_stb,
    input  req_ready, resp_valid, resp_data, resp_err, busy, cvt_a, cvt_rst
  );
endinterface

// File: rtl/f2i_share_ctrl.sv
// Shares one float_to_int converter among NREQ requesters with a hang watchdog.
// Latency: grant to resp_valid = 2 + converter latency (TIMEOUT+2 on watchdog expiry).
// Backpressure: one op in flight; req_ready only in IDLE; RESP holds until granted resp_ready.
// Ports: clk, rst (async active-low); bus (slave modport) carries request, response,
// busy and converter signals. Optional macro F2I_SHARE_FIXED_PRIO_EN gives requester 0
// strict priority with round-robin among the rest; undefined means pure round-robin.
module f2i_share_ctrl #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst,
  f2i_share_ctrl_if.slave   bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [31:0]     cvt_a_q, cvt_a_d;
  logic            cvt_rst_q, cvt_rst_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WW-1:0]   wdog_q, wdog_d;

  logic            pick_vld;
  logic [GW-1:0]   pick_idx;
  logic [GW-1:0]   next_rr;

  // Arbiter: first valid index scanning upward from rr_ptr, wrapping.
`ifdef F2I_SHARE_FIXED_PRIO_EN
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    if (bus.req_valid[0]) begin
      pick_vld = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!pick_vld && ((int'(rr_ptr_q) + k) % NREQ) != 0 &&
            bus.req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
          pick_vld = 1'b1;
          pick_idx = GW'((int'(rr_ptr_q) + k) % NREQ);
        end
      end
    end
  end

  // Index 0 never enters the rotation, so wrap to 1.
  assign next_rr = (int'(gnt_q) == NREQ - 1) ? GW'(1) : gnt_q + GW'(1);
`else
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_vld && bus.req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        pick_vld = 1'b1;
        pick_idx = GW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  assign next_rr = (int'(gnt_q) == NREQ - 1) ? '0 : gnt_q + GW'(1);
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cvt_a_q     <= '0;
      cvt_rst_q   <= 1'b1;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      cvt_a_q     <= cvt_a_d;
      cvt_rst_q   <= cvt_rst_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      wdog_q      <= wdog_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cvt_a_d     = cvt_a_q;
    cvt_rst_d   = cvt_rst_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    wdog_d      = wdog_q;
    case (state_q)
      S_IDLE: begin
        cvt_rst_d = 1'b1;
        if (pick_vld) begin
          cvt_a_d = bus.req_data[32*pick_idx +: 32];
          gnt_d   = pick_idx;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // Release the converter; cvt_a stays put until WAIT is left since the
        // converter samples it while unpacking.
        cvt_rst_d = 1'b0;
        wdog_d    = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + WW'(1);
        // Strobe takes precedence over a coincident watchdog expiry.
        if (bus.cvt_z_stb) begin
          resp_data_d = bus.cvt_z;
          resp_err_d  = 1'b0;
          cvt_rst_d   = 1'b1;
          state_d     = S_RESP;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          resp_data_d = 32'h8000_0000;
          resp_err_d  = 1'b1;
          cvt_rst_d   = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready[gnt_q]) begin
          rr_ptr_d = next_rr;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    if (state_q == S_IDLE && pick_vld) bus.req_ready  = NREQ'(1) << pick_idx;
    if (state_q == S_RESP)             bus.resp_valid = NREQ'(1) << gnt_q;
    bus.busy      = (state_q != S_IDLE);
    bus.cvt_a     = cvt_a_q;
    bus.cvt_rst   = cvt_rst_q;
    bus.resp_data = resp_data_q;
    bus.resp_err  = resp_err_q;
  end
endmodule

// File: tb/tb_f2i_share_ctrl.sv
// Directed bench for f2i_share_ctrl with a behavioural converter model.
// Latency: model strobes LAT cycles after release from reset.
// Backpressure: resp_ready driven per scenario.
module tb_f2i_share_ctrl;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 63;
  localparam int LAT     = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   hang     = 1'b0;
  int   mcnt     = 0;

  f2i_share_ctrl_if #(.NREQ(NREQ)) bus ();

  f2i_share_ctrl #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Converter stand-in: hand-tabulated results for the operands used here.
  function automatic logic [31:0] cvt_table(input logic [31:0] a);
    case (a)
      32'h3F80_0000: return 32'h0000_0001;
      32'hC020_0000: return 32'hFFFF_FFFE;
      32'h4F00_0000: return 32'h8000_0000;
      32'h0000_0000: return 32'h0000_0000;
      default:       return 32'h1234_5678;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.cvt_rst) begin
      mcnt          <= 0;
      bus.cvt_z_stb <= 1'b0;
      bus.cvt_z     <= '0;
    end else if (!hang) begin
      mcnt <= mcnt + 1;
      if (mcnt == LAT - 1) begin
        bus.cvt_z_stb <= 1'b1;
        bus.cvt_z     <= cvt_table(bus.cvt_a);
      end
    end
  end

  task automatic issue(input int r, input logic [31:0] a, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.req_valid[r]         = 1'b1;
    bus.req_data[32*r +: 32] = a;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (bus.req_ready[r]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic wait_resp(output logic [NREQ-1:0] vec, output logic [31:0] d, output logic e,
                           output int cyc, output bit pstb, output bit ok);
    bit last_stb;
    ok = 1'b0; cyc = 0; vec = '0; d = '0; e = 1'b0; pstb = 1'b0;
    last_stb = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.resp_valid != '0) begin
        ok = 1'b1; vec = bus.resp_valid; d = bus.resp_data; e = bus.resp_err; pstb = last_stb;
        break;
      end
      last_stb = bus.cvt_z_stb;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.req_valid = '0; bus.req_data = '0; bus.resp_ready = '1;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.cvt_rst !== 1'b1) begin failures++; $display("FAIL reset_cvt_rst got=%b want=1", bus.cvt_rst); end
    checks++; if (bus.cvt_a !== 32'h0) begin failures++; $display("FAIL reset_cvt_a got=%h want=0", bus.cvt_a); end
    checks++; if (bus.resp_valid !== 2'b00 || bus.resp_data !== 32'h0 || bus.resp_err !== 1'b0)
      begin failures++; $display("FAIL reset_resp got=%b/%h/%b want=00/0/0", bus.resp_valid, bus.resp_data, bus.resp_err); end
    rst = 1'b1;
  endtask

  task automatic test_basic;
    bit ok, pstb; logic [NREQ-1:0] v; logic [31:0] d; logic e; int cyc;
    issue(0, 32'h3F80_0000, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_grant got=%b want=1", ok); end
    wait_resp(v, d, e, cyc, pstb, ok);
    checks++; if (v !== 2'b01) begin failures++; $display("FAIL basic_vec got=%b want=01", v); end
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL basic_data got=%h want=00000001", d); end
    checks++; if (e !== 1'b0)  begin failures++; $display("FAIL basic_err got=%b want=0", e); end
    checks++; if (cyc !== 2 + LAT + 1) begin failures++; $display("FAIL basic_latency got=%0d want=%0d", cyc, 2 + LAT + 1); end
    checks++; if (pstb !== 1'b1 || bus.cvt_rst !== 1'b1)
      begin failures++; $display("FAIL basic_cvt_rst got=stb%b/rst%b want=stb1/rst1", pstb, bus.cvt_rst); end
  endtask

  task automatic test_negative;
    bit ok, pstb, seen0; logic [NREQ-1:0] v; logic [31:0] d; logic e; int cyc;
    issue(1, 32'hC020_0000, ok);
    seen0 = 1'b0;
    wait_resp(v, d, e, cyc, pstb, ok);
    if (v[0]) seen0 = 1'b1;
    @(negedge clk);
    if (bus.resp_valid[0]) seen0 = 1'b1;
    checks++; if (v !== 2'b10) begin failures++; $display("FAIL neg_vec got=%b want=10", v); end
    checks++; if (d !== 32'hFFFF_FFFE) begin failures++; $display("FAIL neg_data got=%h want=fffffffe", d); end
    checks++; if (seen0 !== 1'b0) begin failures++; $display("FAIL neg_req0_resp got=%b want=0", seen0); end
  endtask

  task automatic test_round_robin;
    bit ok, pstb; logic [NREQ-1:0] v, ev; logic [31:0] d, ed; logic e; int cyc;
    @(negedge clk);
    bus.req_data  = {32'h0000_0000, 32'h4F00_0000};
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
`ifdef F2I_SHARE_FIXED_PRIO_EN
      ev = 2'b01;
`else
      ev = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      ed = (ev == 2'b01) ? 32'h8000_0000 : 32'h0000_0000;
      wait_resp(v, d, e, cyc, pstb, ok);
      checks++; if (v !== ev) begin failures++; $display("FAIL rr_grant%0d got=%b want=%b", i, v, ev); end
      checks++; if (d !== ed) begin failures++; $display("FAIL rr_data%0d got=%h want=%h", i, d, ed); end
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_timeout;
    bit ok, pstb; logic [NREQ-1:0] v; logic [31:0] d; logic e; int cyc;
    hang = 1'b1;
    issue(0, 32'h3F80_0000, ok);
    wait_resp(v, d, e, cyc, pstb, ok);
    checks++; if (cyc !== TIMEOUT + 2) begin failures++; $display("FAIL to_cycles got=%0d want=%0d", cyc, TIMEOUT + 2); end
    checks++; if (v !== 2'b01 || d !== 32'h8000_0000 || e !== 1'b1)
      begin failures++; $display("FAIL to_resp got=%b/%h/%b want=01/80000000/1", v, d, e); end
    hang = 1'b0;
    issue(1, 32'h3F80_0000, ok);
    wait_resp(v, d, e, cyc, pstb, ok);
    checks++; if (v !== 2'b10 || d !== 32'h1 || e !== 1'b0)
      begin failures++; $display("FAIL to_recover got=%b/%h/%b want=10/00000001/0", v, d, e); end
  endtask

  task automatic test_stall;
    bit ok, pstb; logic [NREQ-1:0] v; logic [31:0] d; logic e; int cyc;
    bus.resp_ready = 2'b10;
    issue(0, 32'h3F80_0000, ok);
    wait_resp(v, d, e, cyc, pstb, ok);
    checks++; if (v !== 2'b01 || d !== 32'h1) begin failures++; $display("FAIL stall_first got=%b/%h want=01/00000001", v, d); end
    bus.req_data[63:32] = 32'hC020_0000;
    bus.req_valid[1]    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 32'h1)
        begin failures++; $display("FAIL stall_hold%0d got=%b/%h want=01/00000001", i, bus.resp_valid, bus.resp_data); end
      checks++; if (bus.req_ready !== 2'b00) begin failures++; $display("FAIL stall_ready%0d got=%b want=00", i, bus.req_ready); end
    end
    bus.resp_ready = 2'b01;
    @(negedge clk); #1;
    checks++; if (bus.req_ready !== 2'b10) begin failures++; $display("FAIL stall_regrant got=%b want=10", bus.req_ready); end
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    bus.resp_ready   = 2'b11;
    wait_resp(v, d, e, cyc, pstb, ok);
    checks++; if (v !== 2'b10 || d !== 32'hFFFF_FFFE) begin failures++; $display("FAIL stall_second got=%b/%h want=10/fffffffe", v, d); end
  endtask

  task automatic test_reset_in_wait;
    bit ok, pstb, seen; logic [NREQ-1:0] v; logic [31:0] d; logic e; int cyc;
    issue(0, 32'h3F80_0000, ok);
    repeat (3) @(negedge clk);
    checks++; if (bus.cvt_a !== 32'h3F80_0000 || bus.cvt_rst !== 1'b0 || bus.busy !== 1'b1)
      begin failures++; $display("FAIL rw_inwait got=%h/%b/%b want=3f800000/0/1", bus.cvt_a, bus.cvt_rst, bus.busy); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.cvt_rst !== 1'b1 || bus.cvt_a !== 32'h0)
      begin failures++; $display("FAIL rw_async got=%b/%b/%h want=0/1/0", bus.busy, bus.cvt_rst, bus.cvt_a); end
    checks++; if (bus.resp_valid !== 2'b00 || bus.resp_data !== 32'h0 || bus.resp_err !== 1'b0)
      begin failures++; $display("FAIL rw_resp got=%b/%h/%b want=00/0/0", bus.resp_valid, bus.resp_data, bus.resp_err); end
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.resp_valid != '0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rw_no_resp got=%b want=0", seen); end
    issue(1, 32'hC020_0000, ok);
    wait_resp(v, d, e, cyc, pstb, ok);
    checks++; if (v !== 2'b10 || d !== 32'hFFFF_FFFE || e !== 1'b0)
      begin failures++; $display("FAIL rw_after got=%b/%h/%b want=10/fffffffe/0", v, d, e); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_negative;
    test_round_robin;
    test_timeout;
    test_stall;
    test_reset_in_wait;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end
endmodule
